// File: rtl/GPU_Shader_pkg.sv
// Shared shader data-memory types: word, address and write-buffer entry.
// Used by shader_dmem_ctrl and dmem_wbuf.
package GPU_Shader_pkg;

    localparam int MEM_DEPTH      = 256;
    localparam int MEM_AW         = $clog2(MEM_DEPTH);
    localparam int WBUF_DEPTH_DEF = 4;

    typedef logic [31:0]       word_t;
    typedef logic [MEM_AW-1:0] maddr_t;

    typedef struct packed {
        maddr_t addr;
        word_t  data;
    } wbuf_entry_t;

endpackage

// File: rtl/dmem_wbuf.sv
// Store write buffer: in-order FIFO with occupancy count and a
// youngest-match address lookup across all live entries.
module dmem_wbuf
    import GPU_Shader_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  wbuf_entry_t push_entry,
    input  logic        pop,
    input  maddr_t      lookup_addr,
    output wbuf_entry_t head,
    output logic        full,
    output logic        empty,
    output logic        hit,
    output word_t       hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbuf_entry_t       entries [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = entries[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; only the pointers define liveness.
    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= push_entry;
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (entries[idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/shader_dmem_ctrl.sv
// Shader data-memory controller: single-port array behind a store buffer.
// Define DMEM_FWD_EN to let loads forward from buffered stores.
module shader_dmem_ctrl
    import GPU_Shader_pkg::*;
#(
    parameter  int WBUF_DEPTH = WBUF_DEPTH_DEF,
    localparam int AW         = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ready,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    output logic          busy
);

    word_t       mem [MEM_DEPTH];
    wbuf_entry_t push_entry;
    wbuf_entry_t head;
    logic        wb_full;
    logic        wb_empty;
    logic        wb_hit;
    word_t       wb_hit_data;
    logic        wr_acc;
    logic        rd_acc;
    logic        drain;
    word_t       rd_word;

    assign wr_ready = !wb_full;
    assign busy     = !wb_empty;

`ifdef DMEM_FWD_EN
    assign rd_ready = !wb_full;
`else
    assign rd_ready = !wb_full && !wb_hit;
`endif

    assign wr_acc = wr_en && wr_ready;
    assign rd_acc = rd_req && rd_ready;
    assign drain  = !wb_empty && !rd_acc;

    assign push_entry = '{addr: wr_addr, data: wr_data};

    dmem_wbuf #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (wr_acc),
        .push_entry  (push_entry),
        .pop         (drain),
        .lookup_addr (rd_addr),
        .head        (head),
        .full        (wb_full),
        .empty       (wb_empty),
        .hit         (wb_hit),
        .hit_data    (wb_hit_data)
    );

    always_ff @(posedge clk) begin
        if (drain) mem[head.addr] <= head.data;
    end

    // Without forwarding a hit blocks acceptance, so the hit path only
    // ever selects when forwarding is compiled in.
    assign rd_word = wb_hit ? wb_hit_data : mem[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= rd_word;
        end
    end

endmodule

// File: doc/shader_dmem_ctrl.md
SHADER_DMEM_CTRL -- requirements
Module: shader_dmem_ctrl

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 4 (power of two, >=2): write-buffer entries.
REQ-002 SHALL take MEM_DEPTH (word count) and word_t (32-bit) from GPU_Shader_pkg; AW = $clog2(MEM_DEPTH).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  in  1  store request from ALU.
REQ-006 SHALL have port wr_addr  in  AW  store word address.
REQ-007 SHALL have port wr_data  in  32  store data.
REQ-008 SHALL have port wr_ready  out  1  store accepted this cycle when high.
REQ-009 SHALL have port rd_req  in  1  load request.
REQ-010 SHALL have port rd_addr  in  AW  load word address.
REQ-011 SHALL have port rd_ready  out  1  load accepted this cycle when high.
REQ-012 SHALL have port rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-013 SHALL have port rd_data  out  32  load result (feeds ALU mem_read_data).
REQ-014 SHALL have port busy  out  1  write buffer non-empty.

Function
REQ-015 Store accepted iff wr_en && wr_ready; pushed into FIFO write buffer in order.
REQ-016 wr_ready = (count != WBUF_DEPTH); no push when full, even if a drain occurs the same cycle.
REQ-017 Memory array single-port: at most one read or one drain-write per cycle.
REQ-018 Port arbitration: full buffer -> drain wins, rd_ready=0; otherwise accepted read wins, drain waits.
REQ-019 Drain writes oldest entry to array when buffer non-empty and port not used by a read.
REQ-020 Load accepted iff rd_req && rd_ready; rd_valid and rd_data registered, exactly 1 cycle after acceptance.
REQ-021 Load returns youngest buffered entry matching rd_addr if any, else array contents.
REQ-022 Store accepted in the same cycle as a load to the same address is NOT visible to that load.
REQ-023 Simultaneous push and drain: count unchanged; pointers advance modulo WBUF_DEPTH.
REQ-024 rd_data holds last value when rd_valid=0.
REQ-025 busy = (count != 0).

Reset
REQ-026 On rst_n low: pointers and count = 0, wr_ready=1, rd_ready=1, rd_valid=0, rd_data=0, busy=0.
REQ-027 Reset mid-operation discards undrained entries and any pending load; array contents are not reset.

Configuration
REQ-028 Macro DMEM_FWD_EN defined: REQ-021 forwarding from buffer compiled in.
REQ-029 DMEM_FWD_EN undefined: no forwarding; rd_ready=0 while rd_addr matches any buffered entry, until drained.

Structure
REQ-030 GPU_Shader_pkg SHALL hold WBUF_DEPTH default constant and struct wbuf_entry_t {addr, data}.
REQ-031 Sub-module dmem_wbuf SHALL implement FIFO, count, and address-match/youngest-hit logic.

Verification
REQ-032 Reset, idle -> wr_ready=1, rd_ready=1, busy=0, rd_valid=0, rd_data=0.
REQ-033 Store 5<-0xDEADBEEF, idle 2 cycles, load 5 -> rd_valid 1 cycle later, rd_data=0xDEADBEEF, busy=0.
REQ-034 Hold rd_req to addr 9 continuously, store 3<-0x11,4<-0x22 -> stores drain only when full; after release loads of 3,4 return 0x11,0x22.
REQ-035 With DMEM_FWD_EN: store 7<-0xA, 7<-0xB back-to-back, load 7 next cycle -> 0xB; without macro: rd_ready=0 until both drained, then 0xB.
REQ-036 Five back-to-back stores with continuous reads (WBUF_DEPTH=4) -> wr_ready=0 on 5th; drain has priority; 5th accepted after drain.
REQ-037 Assert rst_n low with 3 entries buffered -> busy=0 next cycle, rd_valid=0, buffered data never written.
